// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Optional feature macro: IFU_PERF_CNT_EN (performance counters in ifu_fetch).
package ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Instructions are word aligned; the two low bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// 32-bit free-running event counter; wraps at 2^32, never saturates.
module ifu_perf_cnt
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  // Count one per enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time from
// instruction memory and hands it to decode. Redirects from execute override
// everything and squash whatever fetch is in flight.
// Optional feature macro: IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_kill_cnt.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          XLEN     = 32
)
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_kill_cnt
`endif
);

  ifu_state_e  r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = align_pc(redirect_pc);

  // Fetch FSM: one outstanding request; redirect wins over every other event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_inst    <= INST_NOP;
      r_inst_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          if (imem_req_ready) begin
            // A request accepted alongside a redirect fetches the old PC: squash it.
            r_state <= S_WAIT;
            r_kill  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          if (imem_rsp_valid) begin
            if (r_kill || redirect_valid) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_inst    <= imem_rsp_data;
              r_inst_pc <= r_pc;
              r_state   <= S_HOLD;
            end
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (inst_ready) begin
            r_pc    <= r_pc + PC_STEP;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of flops, so they carry no input-to-output path.
  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;

`ifdef IFU_PERF_CNT_EN
  logic w_fetch_ev;
  logic w_kill_ev;

  // Delivered instruction, and squashed work (stale response or held instruction).
  assign w_fetch_ev = (r_state == S_HOLD) && inst_ready && !redirect_valid;
  assign w_kill_ev  = ((r_state == S_WAIT) && imem_rsp_valid && (r_kill || redirect_valid)) ||
                      ((r_state == S_HOLD) && redirect_valid);

  ifu_perf_cnt u_fetch_cnt (.clk(clk), .rst(rst), .i_en(w_fetch_ev), .o_cnt(perf_fetch_cnt));
  ifu_perf_cnt u_kill_cnt  (.clk(clk), .rst(rst), .i_en(w_kill_ev),  .o_cnt(perf_kill_cnt));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, a zero-wait memory responder, and a
// transaction-level model compared against the DUT every cycle.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'hA5A5_0003;
  endfunction

  // ---- model: what has been fetched/held, in transaction terms ----
  bit          m_started, m_out, m_kill, m_hold;
  logic [31:0] m_pc, m_inst, m_ipc, m_fetch, m_kills;

  task automatic model_reset();
    m_started = 0; m_out = 0; m_kill = 0; m_hold = 0;
    m_pc = RST_PC; m_inst = NOP; m_ipc = RST_PC; m_fetch = 0; m_kills = 0;
  endtask

  initial model_reset();

  task automatic model_step();
    logic [31:0] tgt;
    bit asking;
    tgt    = {redirect_pc[31:2], 2'b00};
    asking = !m_out && !m_hold;
    if (!m_started) begin
      m_started = 1;
      if (redirect_valid) m_pc = tgt;
    end else if (redirect_valid) begin
      m_pc = tgt;
      if (asking) begin
        if (imem_req_ready) begin m_out = 1; m_kill = 1; end
      end else if (m_out) begin
        if (imem_rsp_valid) begin m_out = 0; m_kill = 0; m_kills++; end
        else m_kill = 1;
      end else begin
        m_hold = 0; m_kills++;
      end
    end else if (asking) begin
      if (imem_req_ready) m_out = 1;
    end else if (m_out) begin
      if (imem_rsp_valid) begin
        m_out = 0;
        if (m_kill) begin m_kill = 0; m_kills++; end
        else begin m_hold = 1; m_inst = imem_rsp_data; m_ipc = m_pc; end
      end
    end else if (inst_ready) begin
      m_hold = 0; m_pc = m_pc + 32'd4; m_fetch++;
    end
  endtask

  // ---- memory responder state ----
  bit          hs_q = 0, pend = 0, auto_rsp = 1;
  logic [31:0] addr_q = '0, paddr = '0;

  // Compare process: outputs vs model on every falling edge, then advance model.
  initial forever begin
    @(negedge clk);
    if (!rst) model_reset();
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, m_started && !m_out && !m_hold});
    if (m_started && !m_out && !m_hold) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_kill", perf_kill_cnt, m_kills);
`endif
    hs_q   = rst && imem_req_valid && imem_req_ready;
    addr_q = imem_req_addr;
    if (rst) model_step();
  end

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 0;
    if (hs_q) begin pend = 1; paddr = addr_q; end
    imem_rsp_valid = 0;
    if (auto_rsp && pend) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = mem_word(paddr);
      pend = 0;
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1;
    redirect_pc    = t;
  endtask

  initial begin
    #100000;
    errs++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  logic [31:0] held_i, held_pc, kill0, fetch0;

  initial begin
    // Reset values while held in reset.
    tick(); tick();
    chk("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst inst", inst, 32'h0000_0013);
    chk("rst inst_pc", inst_pc, 32'h8000_0000);
    rst = 1;

    // 1: basic zero-wait fetch.
    tick();
    chk("t1 req_valid c1", {31'd0, imem_req_valid}, 32'd1);
    chk("t1 req_addr c1", imem_req_addr, 32'h8000_0000);
    tick();
    tick();
    chk("t1 inst_valid c3", {31'd0, inst_valid}, 32'd1);
    chk("t1 inst", inst, 32'h0010_0093);
    chk("t1 inst_pc", inst_pc, 32'h8000_0000);
    tick();
    chk("t1 next addr", imem_req_addr, 32'h8000_0004);

    // 2: decode stall for 5 cycles.
    inst_ready = 0;
    tick(); tick();
    chk("t2 inst_valid", {31'd0, inst_valid}, 32'd1);
    held_i = inst; held_pc = inst_pc;
    chk("t2 inst_pc", held_pc, 32'h8000_0004);
    repeat (5) begin
      tick();
      chk("t2 stall valid", {31'd0, inst_valid}, 32'd1);
      chk("t2 stall inst", inst, held_i);
      chk("t2 stall pc", inst_pc, held_pc);
      chk("t2 no req", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1;
    tick();
    chk("t2 next addr", imem_req_addr, 32'h8000_0008);

    // 3a: redirect in S_WAIT before the response arrives.
    auto_rsp = 0;
    tick();
    redirect(32'h8000_0102);
    tick();
    auto_rsp = 1;
    tick();
    tick();
    chk("t3a no inst", {31'd0, inst_valid}, 32'd0);
    chk("t3a req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t3a req_addr", imem_req_addr, 32'h8000_0100);
    // 3b: redirect in the same cycle as the response.
    tick();
    redirect(32'h8000_0104);
    tick();
    chk("t3b no inst", {31'd0, inst_valid}, 32'd0);
    chk("t3b req_addr", imem_req_addr, 32'h8000_0104);

    // 4: redirect and inst_ready together in S_HOLD.
`ifdef IFU_PERF_CNT_EN
    kill0 = perf_kill_cnt; fetch0 = perf_fetch_cnt;
`endif
    tick(); tick();
    chk("t4 hold", {31'd0, inst_valid}, 32'd1);
    redirect(32'h8000_0200);
    tick();
    chk("t4 dropped", {31'd0, inst_valid}, 32'd0);
    chk("t4 req_addr", imem_req_addr, 32'h8000_0200);
`ifdef IFU_PERF_CNT_EN
    chk("t4 kill delta", perf_kill_cnt - kill0, 32'd1);
    chk("t4 fetch same", perf_fetch_cnt, fetch0);
`endif

    // 5: back-pressured request, then redirect while still waiting for ready.
    imem_req_ready = 0;
    repeat (4) begin
      tick();
      chk("t5 req held", {31'd0, imem_req_valid}, 32'd1);
      chk("t5 addr held", imem_req_addr, 32'h8000_0200);
    end
    redirect(32'h8000_0300);
    tick();
    chk("t5 req valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t5 new addr", imem_req_addr, 32'h8000_0300);
    imem_req_ready = 1;
    tick(); tick();
    chk("t5 inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("t5 inst_pc", inst_pc, 32'h8000_0300);
    tick();
    chk("t5 next addr", imem_req_addr, 32'h8000_0304);

    // 6a: PC wrap.
    imem_req_ready = 0;
    redirect(32'hFFFF_FFFC);
    tick();
    chk("t6 addr top", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1;
    tick(); tick();
    chk("t6 inst_pc top", inst_pc, 32'hFFFF_FFFC);
    tick();
    chk("t6 wrap addr", imem_req_addr, 32'h0000_0000);

    // 6b: async reset while waiting on memory; late response must be ignored.
    auto_rsp = 0;
    tick(); tick();
    chk("t6 waiting", {31'd0, imem_req_valid}, 32'd0);
    #2 rst = 0;
    #1;
    chk("t6 async req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t6 async inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6 async inst", inst, 32'h0000_0013);
    chk("t6 async inst_pc", inst_pc, 32'h8000_0000);
    chk("t6 async addr", imem_req_addr, 32'h8000_0000);
    tick();
    rst = 1;
    pend = 0;
    auto_rsp = 1;
    imem_rsp_valid = 1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    chk("t6 restart addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk("t6 no stray inst", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t6 refetch inst", inst, 32'h0010_0093);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
